// File: rtl/adc_frame_buffer.sv
// -----------------------------------------------------------------------------
// adc_frame_buffer
//
// Collects one frame of unsigned (offset-binary) ADC samples into on-chip RAM,
// then streams the frame out as signed two's-complement data over a
// valid/ready/last interface. Single buffer: capture and drain never overlap.
//
// Ports
//   sys_clk     : system clock
//   sys_rst     : asynchronous reset, active-high (synchronous release upstream)
//   start       : one-cycle pulse, arms capture (only honoured in IDLE)
//   sample_in   : unsigned ADC sample, offset binary
//   sample_vld  : one-cycle strobe per sample
//   fft_tdata   : signed sample to the FFT core
//   fft_tvalid  : fft_tdata valid
//   fft_tready  : downstream accepts when tvalid & tready
//   fft_tlast   : marks the final sample of the frame
//   fft_flag    : one-cycle pulse, frame capture complete
//   busy        : high while filling or draining
//   overrun     : sticky, a sample arrived while draining
// -----------------------------------------------------------------------------
module adc_frame_buffer #(
   parameter int DATA_W     = 12,
   parameter int FRAME_LEN  = 1024,
   parameter int ADDR_W     = 10,
   parameter int CONTINUOUS = 0
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst,
   input  logic                     start,
   input  logic [DATA_W-1:0]        sample_in,
   input  logic                     sample_vld,
   output logic signed [DATA_W-1:0] fft_tdata,
   output logic                     fft_tvalid,
   input  logic                     fft_tready,
   output logic                     fft_tlast,
   output logic                     fft_flag,
   output logic                     busy,
   output logic                     overrun
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
   localparam bit                REARM     = (CONTINUOUS != 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Offset binary to two's complement: flipping the MSB re-centres the range.
   function automatic logic signed [DATA_W-1:0] to_signed(input logic [DATA_W-1:0] s);
      return $signed({~s[DATA_W-1], s[DATA_W-2:0]});
   endfunction

   logic [DATA_W-1:0] mem [0:FRAME_LEN-1];
   logic [DATA_W-1:0] ram_q;

   state_t                   state_q, state_d;
   logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
   logic                     rd_done_q, rd_done_d;
   logic                     ram_vld_q, ram_vld_d;
   logic                     ram_last_q, ram_last_d;
   logic                     out_vld_q, out_vld_d;
   logic                     out_last_q, out_last_d;
   logic signed [DATA_W-1:0] out_data_q, out_data_d;
   logic                     flag_q, flag_d;
   logic                     overrun_q, overrun_d;

   logic mem_we;
   logic ram_en;
   logic out_ready;
   logic ram_load;

   // Two-stage read pipeline: RAM output register (ram_q) feeding the output
   // register. Each stage loads whenever the stage after it can move, so a
   // stall on fft_tready freezes both stages and a steady tready=1 gives one
   // beat per cycle without bubbles.
   always_comb begin
      state_d    = state_q;
      wr_addr_d  = wr_addr_q;
      rd_addr_d  = rd_addr_q;
      rd_done_d  = rd_done_q;
      ram_vld_d  = ram_vld_q;
      ram_last_d = ram_last_q;
      out_vld_d  = out_vld_q;
      out_last_d = out_last_q;
      out_data_d = out_data_q;
      flag_d     = 1'b0;
      overrun_d  = overrun_q;
      mem_we     = 1'b0;
      ram_en     = 1'b0;
      out_ready  = ~out_vld_q | fft_tready;
      ram_load   = ~ram_vld_q | out_ready;

      case (state_q)
         ST_IDLE: begin
            // A sample coinciding with start is deliberately not stored.
            if (start) begin
               state_d   = ST_FILL;
               wr_addr_d = '0;
               overrun_d = 1'b0;
            end
         end

         ST_FILL: begin
            if (sample_vld) begin
               mem_we    = 1'b1;
               wr_addr_d = wr_addr_q + 1'b1;
               if (wr_addr_q == LAST_ADDR) begin
                  state_d   = ST_DRAIN;
                  flag_d    = 1'b1;
                  rd_addr_d = '0;
                  rd_done_d = 1'b0;
               end
            end
         end

         ST_DRAIN: begin
            if (sample_vld) begin
               overrun_d = 1'b1;
            end

            if (out_ready) begin
               out_vld_d  = ram_vld_q;
               out_last_d = ram_vld_q & ram_last_q;
               if (ram_vld_q) begin
                  out_data_d = to_signed(ram_q);
               end
            end

            if (ram_load) begin
               ram_vld_d = ~rd_done_q;
               if (!rd_done_q) begin
                  ram_en     = 1'b1;
                  ram_last_d = (rd_addr_q == LAST_ADDR);
                  rd_addr_d  = rd_addr_q + 1'b1;
                  rd_done_d  = (rd_addr_q == LAST_ADDR);
               end
            end

            if (out_vld_q && out_last_q && fft_tready) begin
               state_d    = REARM ? ST_FILL : ST_IDLE;
               wr_addr_d  = '0;
               out_vld_d  = 1'b0;
               out_last_d = 1'b0;
               ram_vld_d  = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q    <= ST_IDLE;
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         rd_done_q  <= 1'b0;
         ram_vld_q  <= 1'b0;
         ram_last_q <= 1'b0;
         out_vld_q  <= 1'b0;
         out_last_q <= 1'b0;
         out_data_q <= '0;
         flag_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_addr_q  <= wr_addr_d;
         rd_addr_q  <= rd_addr_d;
         rd_done_q  <= rd_done_d;
         ram_vld_q  <= ram_vld_d;
         ram_last_q <= ram_last_d;
         out_vld_q  <= out_vld_d;
         out_last_q <= out_last_d;
         out_data_q <= out_data_d;
         flag_q     <= flag_d;
         overrun_q  <= overrun_d;
      end
   end

   // Frame RAM with registered, enabled read port; contents survive reset.
   always_ff @(posedge sys_clk) begin
      if (mem_we) begin
         mem[wr_addr_q] <= sample_in;
      end
      if (ram_en) begin
         ram_q <= mem[rd_addr_q];
      end
   end

   assign fft_tdata  = out_data_q;
   assign fft_tvalid = out_vld_q;
   assign fft_tlast  = out_last_q;
   assign fft_flag   = flag_q;
   assign busy       = (state_q != ST_IDLE);
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_adc_frame_buffer.sv
// -----------------------------------------------------------------------------
// Bench for adc_frame_buffer. Two instances: a short non-continuous frame
// buffer for the main scenarios and a continuous one for back-to-back frames.
// Expected output of every beat is sample ^ 0x800 taken as a signed value.
// -----------------------------------------------------------------------------
module tb_adc_frame_buffer;

   localparam int DW  = 12;
   localparam int FL  = 32;
   localparam int AW  = 5;
   localparam int FLC = 8;
   localparam int AWC = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic          start = 1'b0, sample_vld = 1'b0, fft_tready = 1'b0;
   logic [DW-1:0] sample_in = '0;
   logic [DW-1:0] fft_tdata;
   logic          fft_tvalid, fft_tlast, fft_flag, busy, overrun;

   logic          c_start = 1'b0, c_vld = 1'b0, c_tready = 1'b1;
   logic [DW-1:0] c_sample_in = '0;
   logic [DW-1:0] c_tdata;
   logic          c_tvalid, c_tlast, c_flag, c_busy, c_overrun;

   int n_tests   = 0;
   int n_fail    = 0;
   int flag_cnt  = 0;
   int cflag_cnt = 0;

   logic [DW-1:0] smp [0:FL-1];
   logic [DW-1:0] got [0:FL-1];

   adc_frame_buffer #(.DATA_W(DW), .FRAME_LEN(FL), .ADDR_W(AW), .CONTINUOUS(0)) u_dut (
      .sys_clk    (clk),
      .sys_rst    (rst),
      .start      (start),
      .sample_in  (sample_in),
      .sample_vld (sample_vld),
      .fft_tdata  (fft_tdata),
      .fft_tvalid (fft_tvalid),
      .fft_tready (fft_tready),
      .fft_tlast  (fft_tlast),
      .fft_flag   (fft_flag),
      .busy       (busy),
      .overrun    (overrun)
   );

   adc_frame_buffer #(.DATA_W(DW), .FRAME_LEN(FLC), .ADDR_W(AWC), .CONTINUOUS(1)) u_cont (
      .sys_clk    (clk),
      .sys_rst    (rst),
      .start      (c_start),
      .sample_in  (c_sample_in),
      .sample_vld (c_vld),
      .fft_tdata  (c_tdata),
      .fft_tvalid (c_tvalid),
      .fft_tready (c_tready),
      .fft_tlast  (c_tlast),
      .fft_flag   (c_flag),
      .busy       (c_busy),
      .overrun    (c_overrun)
   );

   always #10 clk = ~clk;

   // Counts cycles with fft_flag high (value sampled just before each edge).
   always @(posedge clk) begin
      if (fft_flag) flag_cnt++;
      if (c_flag)   cflag_cnt++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      n_tests++;
      if (got_v !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got_v, exp_v);
      end
   endtask

   task automatic set_pattern(input int base);
      for (int i = 0; i < FL; i++) smp[i] = DW'(base + i * 131);
   endtask

   // One strobe every two cycles; returns on the negedge after the last write.
   task automatic fill(input bit which, input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         @(negedge clk);
         if (which) begin
            c_sample_in = smp[i];
            c_vld       = 1'b1;
         end else begin
            sample_in  = smp[i];
            sample_vld = 1'b1;
         end
         @(negedge clk);
         c_vld      = 1'b0;
         sample_vld = 1'b0;
      end
   endtask

   task automatic pulse_start;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain(input bit rnd, input string tag, output int first);
      int beats = 0, cyc = 0, stall_err = 0, data_err = 0, last_err = 0;
      logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
      logic [DW-1:0] pd = '0;
      first = -1;
      while (beats < FL && cyc < 4000) begin
         fft_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (fft_tvalid && first < 0) first = cyc;
         if (pv && !pr && (!fft_tvalid || fft_tdata !== pd || fft_tlast !== pl)) stall_err++;
         if (fft_tvalid && fft_tready) begin
            got[beats] = fft_tdata;
            if (fft_tdata !== (smp[beats] ^ 12'h800)) data_err++;
            if (fft_tlast !== (beats == FL - 1))     last_err++;
            beats++;
         end
         pv = fft_tvalid;
         pr = fft_tready;
         pd = fft_tdata;
         pl = fft_tlast;
         @(negedge clk);
         cyc++;
      end
      fft_tready = 1'b0;
      check_eq({tag, "_beats"},     beats,      FL);
      check_eq({tag, "_data_errs"}, data_err,   0);
      check_eq({tag, "_last_errs"}, last_err,   0);
      check_eq({tag, "_stall_errs"}, stall_err, 0);
      check_eq({tag, "_busy_after"}, busy,      0);
      @(negedge clk);
      check_eq({tag, "_no_extra"},  fft_tvalid, 0);
   endtask

   initial begin
      int first;
      int beats, errs, cyc, total;
      logic [DW-1:0] hold;

      // Reset state
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("rst_tvalid",  fft_tvalid, 0);
      check_eq("rst_tdata",   fft_tdata,  0);
      check_eq("rst_tlast",   fft_tlast,  0);
      check_eq("rst_flag",    fft_flag,   0);
      check_eq("rst_busy",    busy,       0);
      check_eq("rst_overrun", overrun,    0);
      rst = 1'b0;
      @(negedge clk);

      // 1: basic frame, IDLE samples ignored, start+sample not stored, start in FILL ignored
      sample_in  = 12'h123;
      sample_vld = 1'b1;
      @(negedge clk);
      sample_vld = 1'b0;
      check_eq("t1_idle_busy", busy, 0);
      set_pattern(0);
      start      = 1'b1;
      sample_vld = 1'b1;
      sample_in  = 12'hABC;
      @(negedge clk);
      start      = 1'b0;
      sample_vld = 1'b0;
      check_eq("t1_busy_fill", busy, 1);
      fill(0, 0, FL / 2);
      pulse_start();
      fill(0, FL / 2, FL);
      check_eq("t1_flag", fft_flag, 1);
      drain(0, "t1", first);
      check_eq("t1_latency_le2", (first >= 0 && first <= 2), 1);
      check_eq("t1_flag_count", flag_cnt, 1);

      // 2: random backpressure
      set_pattern(1000);
      pulse_start();
      fill(0, 0, FL);
      check_eq("t2_flag", fft_flag, 1);
      drain(1, "t2", first);

      // 3: conversion end points: 0x000 -> -2048 (0x800), 0x800 -> 0, 0xFFF -> +2047 (0x7FF)
      set_pattern(7);
      smp[0] = 12'h000;
      smp[1] = 12'h800;
      smp[2] = 12'hFFF;
      pulse_start();
      fill(0, 0, FL);
      drain(0, "t3", first);
      check_eq("t3_conv_min", got[0], 12'h800);
      check_eq("t3_conv_mid", got[1], 12'h000);
      check_eq("t3_conv_max", got[2], 12'h7FF);

      // 4: sample and start during a stalled DRAIN
      set_pattern(55);
      pulse_start();
      fill(0, 0, FL);
      repeat (3) @(negedge clk);
      check_eq("t4_held_valid", fft_tvalid, 1);
      hold       = fft_tdata;
      sample_in  = 12'h5A5;
      sample_vld = 1'b1;
      start      = 1'b1;
      @(negedge clk);
      sample_vld = 1'b0;
      start      = 1'b0;
      @(negedge clk);
      check_eq("t4_overrun_set", overrun,    1);
      check_eq("t4_tdata_hold",  fft_tdata,  hold);
      check_eq("t4_tvalid_hold", fft_tvalid, 1);
      check_eq("t4_busy",        busy,       1);
      drain(0, "t4", first);
      check_eq("t4_overrun_sticky", overrun, 1);
      pulse_start();
      check_eq("t4_overrun_clear", overrun, 0);
      set_pattern(300);
      fill(0, 0, FL);
      drain(0, "t4b", first);

      // 5: reset mid-FILL, then mid-DRAIN, then a clean frame
      set_pattern(77);
      pulse_start();
      fill(0, 0, FL / 2);
      #2 rst = 1'b1;
      #1;
      check_eq("t5_fill_rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      set_pattern(900);
      pulse_start();
      fill(0, 0, FL);
      check_eq("t5_flag_after_rst", fft_flag, 1);
      fft_tready = 1'b1;
      repeat (12) @(negedge clk);
      check_eq("t5_pre_rst_valid", fft_tvalid, 1);
      #2 rst = 1'b1;
      #1;
      check_eq("t5_rst_tvalid", fft_tvalid, 0);
      check_eq("t5_rst_tdata",  fft_tdata,  0);
      check_eq("t5_rst_tlast",  fft_tlast,  0);
      check_eq("t5_rst_busy",   busy,       0);
      @(negedge clk);
      rst        = 1'b0;
      fft_tready = 1'b0;
      set_pattern(2000);
      pulse_start();
      fill(0, 0, FL);
      drain(1, "t5c", first);

      // 6: continuous mode, three frames from a single start
      c_start = 1'b1;
      @(negedge clk);
      c_start = 1'b0;
      total   = 0;
      for (int f = 0; f < 3; f++) begin
         set_pattern(f * 500 + 3);
         fill(1, 0, FLC);
         check_eq("t6_flag", c_flag, 1);
         beats = 0;
         errs  = 0;
         cyc   = 0;
         while (beats < FLC && cyc < 100) begin
            if (c_tvalid) begin
               if (c_tdata !== (smp[beats] ^ 12'h800)) errs++;
               if (c_tlast !== (beats == FLC - 1))     errs++;
               beats++;
            end
            @(negedge clk);
            cyc++;
         end
         total += beats;
         check_eq("t6_frame_errs",  errs,   0);
         check_eq("t6_rearm_busy",  c_busy, 1);
      end
      @(negedge clk);
      check_eq("t6_total_beats", total,     3 * FLC);
      check_eq("t6_flag_count",  cflag_cnt, 3);
      check_eq("t6_overrun",     c_overrun, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
